// File: rtl/hdma_ddr_arbiter_if.sv
// hdma_ddr_arbiter_if: burst command and beat handshake between the arbiter (master) and the DDR3 controller (slave)
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len : one burst command per grant
//   ddr_wdata_req / ddr_rdata_valid               : one 128-bit beat taken / delivered this cycle
interface hdma_ddr_arbiter_if #(parameter int ADDR_W = 28) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              ddr_wdata_req;
  logic              ddr_rdata_valid;
  modport master (output cmd_valid, cmd_wr, cmd_addr, cmd_len, input cmd_ready, ddr_wdata_req, ddr_rdata_valid);
  modport slave (input cmd_valid, cmd_wr, cmd_addr, cmd_len, output cmd_ready, ddr_wdata_req, ddr_rdata_valid);
endinterface

// File: rtl/hdma_ddr_arbiter.sv
// hdma_ddr_arbiter: round-robin sharing of one DDR3 burst port between write/read of two video channels
//   clk_100, rst (sync, active-high), init_done, wr_load_1/_2, rd_load : control
//   wfifo_rcount_1/_2, rfifo_wcount_1/_2 : FIFO fill levels driving the requests
//   ddr (hdma_ddr_arbiter_if.master)     : burst command + beat handshake
//   wfifo_rden_1/_2, rfifo_wren_1/_2     : combinational FIFO strobes of the granted channel
//   wr_opera_en_2 (wfifo_dout select), busy
//   Optional macro HDMA_ARB_PINGPONG_EN: two frame banks per channel
module hdma_ddr_arbiter #(
  parameter int                ADDR_W      = 28,
  parameter int                BURST_LEN   = 64,
  parameter int                FRAME_WORDS = 115200,
  parameter int                FIFO_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE_1      = 'h0000000,
  parameter logic [ADDR_W-1:0] BASE_2      = 'h0080000
) (
  input  logic               clk_100,
  input  logic               rst,
  input  logic               init_done,
  input  logic               wr_load_1,
  input  logic               wr_load_2,
  input  logic               rd_load,
  input  logic [10:0]        wfifo_rcount_1,
  input  logic [10:0]        wfifo_rcount_2,
  input  logic [10:0]        rfifo_wcount_1,
  input  logic [10:0]        rfifo_wcount_2,
  hdma_ddr_arbiter_if.master ddr,
  output logic               wfifo_rden_1,
  output logic               wfifo_rden_2,
  output logic               rfifo_wren_1,
  output logic               rfifo_wren_2,
  output logic               wr_opera_en_2,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;
  localparam logic [ADDR_W-1:0] BL    = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FW    = ADDR_W'(FRAME_WORDS);
  localparam logic [7:0]        LEN   = 8'(BURST_LEN);
  localparam logic [10:0]       BL11  = 11'(BURST_LEN);
  localparam logic [11:0]       BL12  = 12'(BURST_LEN);
  localparam logic [11:0]       DEPTH = 12'(FIFO_DEPTH);
  // Requester index: 0 = W1, 1 = R1, 2 = W2, 3 = R2 (bit 0 = read, bit 1 = ch2)
  state_t            state_q;
  logic [1:0]        ptr_q, g_q, win, idx;
  logic [3:0]        pend_q, pend_in, req;
  logic [ADDR_W-1:0] off_q [4];
  logic [ADDR_W-1:0] addr_d, cmd_addr_q;
  logic [7:0]        cnt_q, cmd_len_q;
  logic              found, app, beat, cmd_wr_q, opera_q;
`ifdef HDMA_ARB_PINGPONG_EN
  logic [3:0]        bank_q, bank_d;
`endif
  always_comb begin
    // Loads take effect only when no burst is in flight: IDLE, or DONE after the offset update
    app = state_q == IDLE || state_q == DONE;
    pend_in = pend_q | {rd_load, wr_load_2, rd_load, wr_load_1};
    req = {4{init_done}} & {({1'b0, rfifo_wcount_2} + BL12) <= DEPTH, wfifo_rcount_2 >= BL11,
                            ({1'b0, rfifo_wcount_1} + BL12) <= DEPTH, wfifo_rcount_1 >= BL11};
    win = '0;
    idx = '0;
    found = 1'b0;
    // Scan from farthest to nearest so the last hit is the first active requester from ptr_q
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    beat = state_q == WDATA ? ddr.ddr_wdata_req : state_q == RDATA && ddr.ddr_rdata_valid;
`ifdef HDMA_ARB_PINGPONG_EN
    bank_d = bank_q;
    if (app) begin
      bank_d[0] = bank_q[0] ^ pend_in[0];
      bank_d[2] = bank_q[2] ^ pend_in[2];
      bank_d[1] = pend_in[1] ? ~bank_d[0] : bank_q[1];
      bank_d[3] = pend_in[1] ? ~bank_d[2] : bank_q[3];
    end
    addr_d = (win[1] ? BASE_2 : BASE_1) + (pend_in[win] ? '0 : off_q[win]) + (bank_d[win] ? FW : '0);
`else
    addr_d = (win[1] ? BASE_2 : BASE_1) + (pend_in[win] ? '0 : off_q[win]);
`endif
  end
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      g_q <= '0;
      pend_q <= '0;
      cnt_q <= '0;
      cmd_wr_q <= 1'b0;
      cmd_addr_q <= '0;
      cmd_len_q <= '0;
      opera_q <= 1'b0;
      for (int i = 0; i < 4; i++) off_q[i] <= '0;
`ifdef HDMA_ARB_PINGPONG_EN
      bank_q <= '0;
`endif
    end else begin
      pend_q <= app ? '0 : pend_in;
`ifdef HDMA_ARB_PINGPONG_EN
      bank_q <= bank_d;
`endif
      // A load in DONE overrides the increment of the finishing burst
      for (int i = 0; i < 4; i++)
        if (app && pend_in[i]) off_q[i] <= '0;
        else if (state_q == DONE && g_q == 2'(i)) off_q[i] <= (off_q[i] + BL + BL > FW) ? '0 : off_q[i] + BL;
      if (beat) cnt_q <= cnt_q == LEN - 8'd1 ? '0 : cnt_q + 8'd1;
      case (state_q)
        IDLE: if (found) begin
          state_q <= CMD;
          g_q <= win;
          ptr_q <= win + 2'd1;
          cmd_wr_q <= ~win[0];
          cmd_addr_q <= addr_d;
          cmd_len_q <= LEN;
          if (!win[0]) opera_q <= win[1];
        end
        CMD: if (ddr.cmd_ready) state_q <= cmd_wr_q ? WDATA : RDATA;
        WDATA, RDATA: if (beat && cnt_q == LEN - 8'd1) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ddr.cmd_valid = state_q == CMD;
  assign ddr.cmd_wr = cmd_wr_q;
  assign ddr.cmd_addr = cmd_addr_q;
  assign ddr.cmd_len = cmd_len_q;
  assign wfifo_rden_1 = state_q == WDATA && g_q == 2'd0 && ddr.ddr_wdata_req;
  assign wfifo_rden_2 = state_q == WDATA && g_q == 2'd2 && ddr.ddr_wdata_req;
  assign rfifo_wren_1 = state_q == RDATA && g_q == 2'd1 && ddr.ddr_rdata_valid;
  assign rfifo_wren_2 = state_q == RDATA && g_q == 2'd3 && ddr.ddr_rdata_valid;
  assign wr_opera_en_2 = opera_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_hdma_ddr_arbiter.sv
// tb_hdma_ddr_arbiter: directed check of grant order, addressing, wrap, loads and reset (FRAME_WORDS shrunk to 256)
module tb_hdma_ddr_arbiter;
  logic        clk = 1'b0, rst = 1'b1, init_done = 1'b0;
  logic        wr_load_1 = 1'b0, wr_load_2 = 1'b0, rd_load = 1'b0;
  logic [10:0] wc1 = '0, wc2 = '0, rc1 = 11'd1024, rc2 = 11'd1024;
  logic        wfifo_rden_1, wfifo_rden_2, rfifo_wren_1, rfifo_wren_2, wr_opera_en_2, busy;
  int          n_cmp = 0, n_err = 0;
  int          c_w1 = 0, c_w2 = 0, c_r1 = 0, c_r2 = 0;
  int          seen, s1, s2, n;
  logic        t_wr, t_op;
  logic [27:0] t_addr;
  hdma_ddr_arbiter_if #(.ADDR_W(28)) ddr ();
  hdma_ddr_arbiter #(.FRAME_WORDS(256)) dut (
    .clk_100(clk), .rst(rst), .init_done(init_done),
    .wr_load_1(wr_load_1), .wr_load_2(wr_load_2), .rd_load(rd_load),
    .wfifo_rcount_1(wc1), .wfifo_rcount_2(wc2), .rfifo_wcount_1(rc1), .rfifo_wcount_2(rc2),
    .ddr(ddr),
    .wfifo_rden_1(wfifo_rden_1), .wfifo_rden_2(wfifo_rden_2),
    .rfifo_wren_1(rfifo_wren_1), .rfifo_wren_2(rfifo_wren_2),
    .wr_opera_en_2(wr_opera_en_2), .busy(busy)
  );
  assign ddr.cmd_ready = 1'b1;
  assign ddr.ddr_wdata_req = 1'b1;
  assign ddr.ddr_rdata_valid = 1'b1;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wfifo_rden_1) c_w1++;
    if (wfifo_rden_2) c_w2++;
    if (rfifo_wren_1) c_r1++;
    if (rfifo_wren_2) c_r2++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset(input logic [10:0] w1, input logic [10:0] w2, input logic [10:0] r1, input logic [10:0] r2, input logic init);
    @(negedge clk);
    rst = 1'b1;
    wc1 = w1; wc2 = w2; rc1 = r1; rc2 = r2;
    init_done = init;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic next_cmd(input string tag, output int cyc);
    logic ok;
    ok = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (ddr.cmd_valid) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
    end
    chk({tag, ".timeout"}, 32'(ok), 32'd1);
    t_wr = ddr.cmd_wr;
    t_addr = ddr.cmd_addr;
    t_op = wr_opera_en_2;
  endtask
  task automatic expect_cmd(input string tag, input logic wr, input logic [27:0] addr, input logic op);
    int cyc;
    next_cmd(tag, cyc);
    chk({tag, ".wr"}, 32'(t_wr), 32'(wr));
    chk({tag, ".addr"}, 32'(t_addr), 32'(addr));
    chk({tag, ".opera"}, 32'(t_op), 32'(op));
  endtask
  initial begin
    do_reset(11'd0, 11'd0, 11'd1024, 11'd1024, 1'b0);
    chk("rst_outs", {24'd0, ddr.cmd_valid, ddr.cmd_wr, busy, wfifo_rden_1, wfifo_rden_2, rfifo_wren_1, rfifo_wren_2, wr_opera_en_2}, 32'd0);
    chk("rst_addr", 32'(ddr.cmd_addr), 32'd0);
    chk("rst_len", 32'(ddr.cmd_len), 32'd0);
    // all four hungry but DDR not calibrated
    wc1 = 11'd64; wc2 = 11'd64; rc1 = 11'd0; rc2 = 11'd0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      seen += int'(ddr.cmd_valid);
    end
    chk("t1_masked", 32'(seen), 32'd0);
    init_done = 1'b1;
    @(negedge clk);
    chk("t1_lat", 32'(ddr.cmd_valid), 32'd1);
    chk("t1_wr", 32'(ddr.cmd_wr), 32'd1);
    chk("t1_addr", 32'(ddr.cmd_addr), 32'd0);
    s1 = c_w1;
    next_cmd("t3_r1", n);
    chk("t3_turn", 32'(n), 32'd67);
    chk("t3_r1.wr", 32'(t_wr), 32'd0);
    chk("t3_r1.addr", 32'(t_addr), 32'd0);
    chk("t3_w1_beats", 32'(c_w1 - s1), 32'd64);
    s1 = c_r1; s2 = c_r2;
    expect_cmd("t3_w2", 1'b1, 28'h80000, 1'b1);
    chk("t3_r1_beats", 32'(c_r1 - s1), 32'd64);
    chk("t3_r2_quiet", 32'(c_r2 - s2), 32'd0);
    expect_cmd("t3_r2", 1'b0, 28'h80000, 1'b1);
    expect_cmd("t3_w1b", 1'b1, 28'd64, 1'b0);
    // writes only: W1 and W2 alternate
    do_reset(11'd64, 11'd64, 11'd1024, 11'd1024, 1'b1);
    expect_cmd("t2_w1a", 1'b1, 28'h0, 1'b0);
    chk("t2_len", 32'(ddr.cmd_len), 32'd64);
    expect_cmd("t2_w2a", 1'b1, 28'h80000, 1'b1);
    expect_cmd("t2_w1b", 1'b1, 28'h40, 1'b0);
    expect_cmd("t2_w2b", 1'b1, 28'h80040, 1'b1);
    // W1 only: offsets 0,64,128,192 then wrap
    do_reset(11'd64, 11'd0, 11'd1024, 11'd1024, 1'b1);
    for (int k = 0; k < 5; k++) expect_cmd($sformatf("t4_w1_%0d", k), 1'b1, 28'((k * 64) % 256), 1'b0);
    // wr_load_1 inside a burst
    do_reset(11'd64, 11'd0, 11'd1024, 11'd1024, 1'b1);
    expect_cmd("t5_w1a", 1'b1, 28'd0, 1'b0);
    expect_cmd("t5_w1b", 1'b1, 28'd64, 1'b0);
    s1 = c_w1;
    repeat (11) @(negedge clk);
    wr_load_1 = 1'b1;
    @(negedge clk);
    wr_load_1 = 1'b0;
    expect_cmd("t5_after", 1'b1, 28'd0, 1'b0);
    chk("t5_beats", 32'(c_w1 - s1), 32'd64);
    expect_cmd("t5_next", 1'b1, 28'd64, 1'b0);
    // reset during a read burst
    do_reset(11'd0, 11'd0, 11'd0, 11'd1024, 1'b1);
    expect_cmd("t6_r1", 1'b0, 28'd0, 1'b0);
    s1 = c_r1;
    expect_cmd("t6_r1b", 1'b0, 28'd64, 1'b0);
    repeat (5) @(negedge clk);
    chk("t6_wren", 32'(rfifo_wren_1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_outs", {24'd0, ddr.cmd_valid, ddr.cmd_wr, busy, wfifo_rden_1, wfifo_rden_2, rfifo_wren_1, rfifo_wren_2, wr_opera_en_2}, 32'd0);
    chk("t6_addr", 32'(ddr.cmd_addr), 32'd0);
    chk("t6_len", 32'(ddr.cmd_len), 32'd0);
    rst = 1'b0;
    expect_cmd("t6_restart", 1'b0, 28'd0, 1'b0);
`ifdef HDMA_ARB_PINGPONG_EN
    do_reset(11'd0, 11'd0, 11'd1024, 11'd1024, 1'b0);
    wr_load_1 = 1'b1;
    @(negedge clk);
    wr_load_1 = 1'b0;
    rd_load = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    wc1 = 11'd64; rc1 = 11'd0; init_done = 1'b1;
    expect_cmd("pp_w1", 1'b1, 28'd256, 1'b0);
    expect_cmd("pp_r1", 1'b0, 28'd0, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
